// File: rtl/aes_iter_core.sv
// Iterative AES-128 encryption core; ROUNDS_PER_CYCLE rounds are evaluated per clock.
// Optional macro AES_KEY_HOLD_EN adds key_hold to reuse the key of the previous accepted block.
module aes_iter_core #(
    parameter int BYTE             = 8,
    parameter int DWORD            = 32,
    parameter int LENGTH           = 128,
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LENGTH-1:0] plain_text,
    input  logic [LENGTH-1:0] key,
`ifdef AES_KEY_HOLD_EN
    input  logic              key_hold,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LENGTH-1:0] cipher_text,
    output logic              busy
);

    localparam int N = 10 / ROUNDS_PER_CYCLE;
    localparam logic [3:0] LAST_START = 4'(1 + (N - 1) * ROUNDS_PER_CYCLE);

    if (LENGTH != 128) begin : g_bad_length
        $error("aes_iter_core: LENGTH must be 128");
    end
    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
          ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
        $error("aes_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
    end

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [LENGTH-1:0] r_blk, r_rk, r_cipher;
    logic [3:0]        r_round;
    logic              r_out_valid;
    logic [LENGTH-1:0] w_chain_st, w_chain_rk, w_key;
    logic              w_accept, w_finish, w_release;

    // Byte i of a block (FIPS-197 order, byte 0 at the MSB) sits at this LSB position.
    function automatic int bpos(input int i);
        return LENGTH - BYTE - BYTE * i;
    endfunction

    function automatic logic [BYTE-1:0] sbox(input logic [BYTE-1:0] b);
        return SBOX[(255 - int'(b)) * BYTE +: BYTE];
    endfunction

    function automatic logic [BYTE-1:0] xtime(input logic [BYTE-1:0] b);
        return {b[BYTE-2:0], 1'b0} ^ (b[BYTE-1] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [BYTE-1:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [LENGTH-1:0] sub_bytes(input logic [LENGTH-1:0] s);
        logic [LENGTH-1:0] o;
        for (int i = 0; i < 16; i++) o[bpos(i) +: BYTE] = sbox(s[bpos(i) +: BYTE]);
        return o;
    endfunction

    // Row r of the column-major state rotates left by r columns.
    function automatic logic [LENGTH-1:0] shift_rows(input logic [LENGTH-1:0] s);
        logic [LENGTH-1:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[bpos(4 * c + r) +: BYTE] = s[bpos(4 * ((c + r) % 4) + r) +: BYTE];
        return o;
    endfunction

    function automatic logic [LENGTH-1:0] mix_columns(input logic [LENGTH-1:0] s);
        logic [LENGTH-1:0] o;
        logic [BYTE-1:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[bpos(4 * c)     +: BYTE];
            a1 = s[bpos(4 * c + 1) +: BYTE];
            a2 = s[bpos(4 * c + 2) +: BYTE];
            a3 = s[bpos(4 * c + 3) +: BYTE];
            o[bpos(4 * c)     +: BYTE] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[bpos(4 * c + 1) +: BYTE] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[bpos(4 * c + 2) +: BYTE] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[bpos(4 * c + 3) +: BYTE] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [LENGTH-1:0] add_round_key(input logic [LENGTH-1:0] s,
                                                        input logic [LENGTH-1:0] k);
        return s ^ k;
    endfunction

    function automatic logic [LENGTH-1:0] key_expansion(input logic [LENGTH-1:0] k,
                                                        input logic [BYTE-1:0]   rc);
        logic [DWORD-1:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        w0 = k[LENGTH-1 -: DWORD];
        w1 = k[LENGTH-1-DWORD -: DWORD];
        w2 = k[LENGTH-1-2*DWORD -: DWORD];
        w3 = k[DWORD-1:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        t  = t ^ {rc, 24'h000000};
        n0 = w0 ^ t;
        n1 = n0 ^ w1;
        n2 = n1 ^ w2;
        n3 = n2 ^ w3;
        return {n0, n1, n2, n3};
    endfunction

    always_comb begin : p_chain
        logic [LENGTH-1:0] st, rk;
        logic [3:0]        rnd;
        st = r_blk;
        rk = r_rk;
        for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
            rnd = r_round + 4'(i);
            st  = shift_rows(sub_bytes(st));
            if (rnd != 4'd10) st = mix_columns(st);
            rk  = key_expansion(rk, rcon(rnd));
            st  = add_round_key(st, rk);
        end
        w_chain_st = st;
        w_chain_rk = rk;
    end

`ifdef AES_KEY_HOLD_EN
    logic [LENGTH-1:0] r_last_key;

    assign w_key = key_hold ? r_last_key : key;

    always_ff @(posedge clk) begin
        if (!nrst)         r_last_key <= '0;
        else if (w_accept) r_last_key <= w_key;
    end
`else
    assign w_key = key;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        w_release   = 1'b0;
        in_ready    = 1'b0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = nrst;
                if (in_valid && nrst) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (r_round == LAST_START) begin
                    w_finish    = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy = 1'b1;
                if (out_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state     <= IDLE;
            r_blk       <= '0;
            r_rk        <= '0;
            r_round     <= '0;
            r_cipher    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_blk   <= add_round_key(plain_text, w_key);
                r_rk    <= w_key;
                r_round <= 4'd1;
            end
            if (r_state == RUN) begin
                r_blk   <= w_chain_st;
                r_rk    <= w_chain_rk;
                r_round <= r_round + 4'(ROUNDS_PER_CYCLE);
            end
            if (w_finish) begin
                r_cipher    <= w_chain_st;
                r_out_valid <= 1'b1;
            end
            if (w_release) begin
                r_out_valid <= 1'b0;
                r_round     <= '0;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign cipher_text = r_cipher;

endmodule

// File: tb/tb_aes_iter_core.sv
// Self-checking bench for aes_iter_core: FIPS-197 vectors, handshake/latency, backpressure,
// mid-operation reset and randomized traffic against a byte-level AES model.
module tb_aes_iter_core;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         nrst, in_valid, in_ready, out_valid, out_ready, busy, key_hold;
    logic [127:0] plain_text, key, cipher_text;
    logic         iv2, iv5, iv10, ir2, ir5, ir10, ov2, ov5, ov10, bz2, bz5, bz10;
    logic [127:0] ct2, ct5, ct10;

    logic [7:0]   sbox_tab [256];
    logic [127:0] exp_q [$];
    int           n_checks = 0;
    int           n_fail   = 0;

    always #5 clk = ~clk;

    aes_iter_core #(.ROUNDS_PER_CYCLE(1)) dut (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
        .plain_text(plain_text), .key(key),
`ifdef AES_KEY_HOLD_EN
        .key_hold(key_hold),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .cipher_text(cipher_text), .busy(busy));

    aes_iter_core #(.ROUNDS_PER_CYCLE(2)) dut2 (
        .clk(clk), .nrst(nrst), .in_valid(iv2), .in_ready(ir2),
        .plain_text(plain_text), .key(key),
`ifdef AES_KEY_HOLD_EN
        .key_hold(key_hold),
`endif
        .out_valid(ov2), .out_ready(1'b1), .cipher_text(ct2), .busy(bz2));

    aes_iter_core #(.ROUNDS_PER_CYCLE(5)) dut5 (
        .clk(clk), .nrst(nrst), .in_valid(iv5), .in_ready(ir5),
        .plain_text(plain_text), .key(key),
`ifdef AES_KEY_HOLD_EN
        .key_hold(key_hold),
`endif
        .out_valid(ov5), .out_ready(1'b1), .cipher_text(ct5), .busy(bz5));

    aes_iter_core #(.ROUNDS_PER_CYCLE(10)) dut10 (
        .clk(clk), .nrst(nrst), .in_valid(iv10), .in_ready(ir10),
        .plain_text(plain_text), .key(key),
`ifdef AES_KEY_HOLD_EN
        .key_hold(key_hold),
`endif
        .out_valid(ov10), .out_ready(1'b1), .cipher_text(ct10), .busy(bz10));

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   w [44][4];
        logic [7:0]   st [4][4];
        logic [7:0]   sh [4][4];
        logic [7:0]   t [4];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) w[i][j] = k[127 - 8 * (4 * i + j) -: 8];
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
            if (i % 4 == 0) begin
                t[0] = sbox_tab[w[i-1][1]] ^ rc;
                t[1] = sbox_tab[w[i-1][2]];
                t[2] = sbox_tab[w[i-1][3]];
                t[3] = sbox_tab[w[i-1][0]];
                rc   = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ t[j];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) st[c][r] = pt[127 - 8 * (4 * c + r) -: 8] ^ w[c][r];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) sh[c][r] = sbox_tab[st[(c + r) % 4][r]];
            for (int c = 0; c < 4; c++) begin
                if (rnd < 10) begin
                    a0 = sh[c][0]; a1 = sh[c][1]; a2 = sh[c][2]; a3 = sh[c][3];
                    sh[c][0] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    sh[c][1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    sh[c][2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    sh[c][3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
                for (int r = 0; r < 4; r++) st[c][r] = sh[c][r] ^ w[4 * rnd + c][r];
            end
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) res[127 - 8 * (4 * c + r) -: 8] = st[c][r];
        return res;
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic accept_block(input logic [127:0] pt, input logic [127:0] k);
        plain_text = pt;
        key        = k;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 64) begin
            tick();
            cyc++;
        end
    endtask

    task automatic count_out_pulses(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (out_valid) n++;
        end
    endtask

    initial begin
        int           lat, lat2, lat5, lat10, bad, n_ov, acc, cyc;
        logic [127:0] cap, cap2, cap5, cap10;

        nrst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; key_hold = 1'b0;
        iv2 = 1'b0; iv5 = 1'b0; iv10 = 1'b0;
        plain_text = '0; key = '0;
        build_sbox();
        check("model_c1", aes_ref(C1_PT, C1_KEY), C1_CT);

        // reset state
        tick(); tick();
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_cipher", cipher_text, 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        nrst = 1'b1;
        #1;
        check("idle_in_ready", 128'(in_ready), 128'(1));

        // FIPS-197 C.1, one round per clock
        accept_block(C1_PT, C1_KEY);
        check("run_in_ready", 128'(in_ready), 128'(0));
        check("run_busy", 128'(busy), 128'(1));
        wait_out(lat);
        check("c1_latency", 128'(lat), 128'(10));
        check("c1_cipher", cipher_text, C1_CT);
        check("done_in_ready", 128'(in_ready), 128'(0));
        tick();
        check("c1_released", 128'(out_valid), 128'(0));
        check("c1_idle_ready", 128'(in_ready), 128'(1));

        // Appendix B on the unrolled variants
        plain_text = B_PT; key = B_KEY;
        iv2 = 1'b1; iv5 = 1'b1; iv10 = 1'b1;
        tick();
        iv2 = 1'b0; iv5 = 1'b0; iv10 = 1'b0;
        lat2 = 0; lat5 = 0; lat10 = 0; cap2 = '0; cap5 = '0; cap10 = '0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (ov2 && lat2 == 0)   begin lat2 = c;  cap2 = ct2;  end
            if (ov5 && lat5 == 0)   begin lat5 = c;  cap5 = ct5;  end
            if (ov10 && lat10 == 0) begin lat10 = c; cap10 = ct10; end
        end
        check("rpc2_latency", 128'(lat2), 128'(5));
        check("rpc5_latency", 128'(lat5), 128'(2));
        check("rpc10_latency", 128'(lat10), 128'(1));
        check("rpc2_cipher", cap2, B_CT);
        check("rpc5_cipher", cap5, B_CT);
        check("rpc10_cipher", cap10, B_CT);
        check("rpc_idle", 128'({ir2, ir5, ir10, bz2, bz5, bz10}), 128'(6'b111000));

        // backpressure
        out_ready = 1'b0;
        accept_block(B_PT, B_KEY);
        wait_out(lat);
        check("bp_latency", 128'(lat), 128'(10));
        cap = cipher_text;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!out_valid || cipher_text !== cap || in_ready || !busy) bad++;
        end
        check("bp_stable", 128'(bad), 128'(0));
        check("bp_cipher", cipher_text, B_CT);
        out_ready = 1'b1;
        tick();
        check("bp_released", 128'(out_valid), 128'(0));
        check("bp_idle_ready", 128'(in_ready), 128'(1));
        check("bp_cipher_kept", cipher_text, B_CT);
        count_out_pulses(10, n_ov);
        check("bp_single_xfer", 128'(n_ov), 128'(0));

        // input disturbance while running
        accept_block(C1_PT, C1_KEY);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            in_valid   = 1'($urandom_range(0, 1));
            plain_text = {$urandom, $urandom, $urandom, $urandom};
            key        = {$urandom, $urandom, $urandom, $urandom};
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("dist_out_valid", 128'(out_valid), 128'(1));
        check("dist_cipher", cipher_text, C1_CT);
        count_out_pulses(15, n_ov);
        check("dist_no_extra", 128'(n_ov), 128'(0));

        // reset in the middle of a block
        accept_block(C1_PT, C1_KEY);
        for (int i = 0; i < 4; i++) tick();
        nrst = 1'b0;
        #1;
        check("mid_rst_in_ready", 128'(in_ready), 128'(0));
        tick();
        nrst = 1'b1;
        #1;
        check("mid_rst_ready_back", 128'(in_ready), 128'(1));
        check("mid_rst_busy", 128'(busy), 128'(0));
        count_out_pulses(15, n_ov);
        check("mid_rst_no_out", 128'(n_ov), 128'(0));
        accept_block(B_PT, B_KEY);
        wait_out(lat);
        check("post_rst_latency", 128'(lat), 128'(10));
        check("post_rst_cipher", cipher_text, B_CT);
        tick();

`ifdef AES_KEY_HOLD_EN
        key_hold = 1'b0;
        accept_block(B_PT, C1_KEY);
        wait_out(lat);
        check("kh_first", cipher_text, aes_ref(B_PT, C1_KEY));
        tick();
        key_hold = 1'b1;
        accept_block(C1_PT, 128'(0));
        key_hold = 1'b0;
        wait_out(lat);
        check("kh_held_key", cipher_text, C1_CT);
        tick();
`endif

        // randomized traffic with random backpressure
        acc = 0;
        cyc = 0;
        while ((acc < 20 || exp_q.size() != 0) && cyc < 3000) begin
            in_valid   = (acc < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
            plain_text = {$urandom, $urandom, $urandom, $urandom};
            key        = {$urandom, $urandom, $urandom, $urandom};
            out_ready  = ($urandom_range(0, 3) != 0);
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(aes_ref(plain_text, key));
                acc++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("rnd_spurious", 128'(out_valid), 128'(0));
                else                   check("rnd_cipher", cipher_text, exp_q.pop_front());
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("rnd_accepted", 128'(acc), 128'(20));
        check("rnd_drained", 128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_iter_core.md
Name: aes_iter_core

Overview:
Iterative AES-128 encryption core with a valid/ready handshake on both sides. The round datapath is unrolled by a parameter, so 1, 2, 5 or 10 rounds are computed per clock, trading area against latency. It reuses the existing SubBytes, ShiftRows, MixColumns, AddRoundKey and KeyExpansion submodules. It is intended as the area-scalable alternative to the fully pipelined 11-stage cipher.

Parameters:
BYTE, 8, byte width in bits
DWORD, 32, word width in bits
LENGTH, 128, block and key width in bits; only 128 is legal
ROUNDS_PER_CYCLE, 1, rounds computed per clock; legal values 1, 2, 5, 10; any other value is an elaboration error

Ports:
clk  in  1  clock
nrst  in  1  reset, synchronous, active-low
in_valid  in  1  plain_text and key are valid
in_ready  out  1  core can accept a block
plain_text  in  LENGTH  plaintext block, FIPS-197 byte order, MSB = byte 0
key  in  LENGTH  cipher key, same byte order
out_valid  out  1  cipher_text is valid
out_ready  in  1  downstream accepts cipher_text
cipher_text  out  LENGTH  ciphertext result
busy  out  1  high in RUN or DONE

Behaviour:
- Reset (synchronous, active-low) is sampled on the clk edge while nrst=0:
  - state<=IDLE; cipher_text<=0; out_valid<=0; round counter<=0; internal state and round-key registers<=0.
  - in_ready is forced 0 combinationally while nrst=0.
- N = 10/ROUNDS_PER_CYCLE, a localparam.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, busy=0.
  - On an edge where in_valid&&in_ready:
    - state_reg<=plain_text^key (initial AddRoundKey).
    - rk_reg<=key.
    - round<=1.
    - Go to RUN.
  - Otherwise hold.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle, a combinational chain of ROUNDS_PER_CYCLE rounds starts from state_reg and rk_reg.
  - Round r uses round key KeyExpansion(previous key, r), with Rcon indexed by r.
  - Rounds 1..9 apply SubBytes, then ShiftRows, then MixColumns, then AddRoundKey.
  - Round 10 omits MixColumns.
  - Register update: state_reg and rk_reg take the chain output; round<=round+ROUNDS_PER_CYCLE.
  - When the chain includes round 10:
    - cipher_text<=chain output.
    - out_valid<=1.
    - Go to DONE.
    - The round counter never exceeds 11 and wraps to 0 on leaving DONE.
- DONE:
  - out_valid=1, busy=1, in_ready=0.
  - cipher_text is held stable while out_valid&&!out_ready.
  - On out_valid&&out_ready: out_valid<=0 and go to IDLE. cipher_text keeps its last value.
- Latency:
  - A block accepted at edge k gives out_valid=1 after edge k+N.
  - With out_ready tied high, the next block is accepted at edge k+N+2.
  - Throughput is 1 block per N+2 cycles.
- Input changes:
  - in_valid may rise in any state; it is ignored unless in IDLE.
  - plain_text and key are sampled only on the accept edge; later changes have no effect.
- Backpressure: out_ready may stay low indefinitely. The core stalls in DONE and never drops or overwrites the result.
- Reset mid-operation (nrst=0 in RUN or DONE) aborts the block:
  - No out_valid is produced.
  - The first accept after nrst returns high starts a fresh block.
- No x-propagation: every register has a defined value from reset onward.

Optional Feature:
Macro AES_KEY_HOLD_EN.
- Defined:
  - Adds input port key_hold (1 bit).
  - A last-key register stores the key of every accepted block; it resets to 0.
  - If key_hold=1 on the accept edge, the stored key is used and the key port is ignored.
  - If key_hold=0, key is used and the stored key is updated.
- Undefined:
  - The port and register do not exist.
  - The key port is always used.

Test Plan:
1. FIPS-197 C.1, ROUNDS_PER_CYCLE=1, out_ready=1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff accepted at edge k -> out_valid at edge k+10, cipher_text 69c4e0d86a7b0430d8cdb78070b4c55a; in_ready returns high at edge k+11.
2. FIPS-197 Appendix B, each of ROUNDS_PER_CYCLE=2, 5, 10: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> cipher_text 3925841d02dc09fbdc118597196a0b32 after N=5, 2 and 1 cycles respectively.
3. Backpressure: hold out_ready=0 for 20 cycles after out_valid -> cipher_text and out_valid stay stable, in_ready=0; raise out_ready -> a single transfer, then IDLE.
4. Input disturbance: toggle in_valid and change plain_text/key during RUN -> result still equals the case 1 vector; no extra transfer occurs.
5. Reset mid-operation: pull nrst low for one cycle at round 5 -> out_valid never rises, in_ready=0 during reset and then 1; a following Appendix B block gives 3925841d02dc09fbdc118597196a0b32.
6. AES_KEY_HOLD_EN defined: block 1 uses the C.1 key with key_hold=0; block 2 drives pt 00112233445566778899aabbccddeeff, key=0 and key_hold=1 -> cipher_text 69c4e0d86a7b0430d8cdb78070b4c55a.
